lives_manager: RTL and testbench
================================

// Module: lives_manager
// PURPOSE
//  Parametrised life/health tracker for the game core. Counts spare lives, decrements
//  on ball-lost events, gives a post-hit invulnerability window and flags game over.
//  Sits between the ball/paddle collision logic (event source) and the game FSM/HUD
//  (consumers of health, loss_occurred and game_over).
// PARAMETERS
//  HEALTH_W       10        width of the health counter
//  START_HEALTH   3         spare lives loaded on reset/restart
//  MAX_HEALTH     9         saturation ceiling for life gain
//  INVULN_CYCLES  25000000  invulnerability length in clk cycles (0 = no window)
//  Legal only if START_HEALTH <= MAX_HEALTH < 2**HEALTH_W; violation is an elaboration error.
// PORTS
//  clk            in   1         system clock
//  resetn         in   1         synchronous, active-low reset
//  restart        in   1         1-cycle pulse: re-arm a new game without reset
//  lost_health    in   1         1-cycle pulse: ball lost
//  gain_health    in   1         1-cycle pulse: extra-life pickup (see CONFIGURATION)
//  health         out  HEALTH_W  current spare lives
//  invulnerable   out  1         high while the post-hit window runs
//  life_lost      out  1         1-cycle pulse: a life was consumed
//  loss_occurred  out  1         level: game lost, held until reset/restart
//  game_over      out  1         1-cycle pulse on entry to LOST
// BEHAVIOUR
//  Single clock. Reset is synchronous and active-low: sampled on posedge clk only.
//  Reset values: health=START_HEALTH, invulnerable=0, life_lost=0, loss_occurred=0,
//   game_over=0, state=ALIVE, timer=0.
//  All outputs registered; response appears 1 cycle after the sampled input pulse.
//  States:
//   ALIVE : lost_health & health>0  -> health-1, life_lost=1, go INVULN,
//           timer=INVULN_CYCLES-1 (if INVULN_CYCLES==0 stay ALIVE).
//           lost_health & health==0 -> go LOST, loss_occurred=1, game_over=1.
//   INVULN: invulnerable=1; lost_health ignored (no pulse, no decrement);
//           timer decrements each cycle; timer==0 -> ALIVE next cycle.
//   LOST  : all event inputs ignored; health holds 0; exits only on resetn/restart.
//  restart (any state): health=START_HEALTH, loss_occurred=0, invulnerable=0, timer=0,
//   state=ALIVE. Priority: resetn > restart > lost_health/gain_health same cycle.
//  Inputs are pulses; a level held N cycles counts as N events (no edge detect).
//  Pulse outputs (life_lost, game_over) are high exactly 1 cycle.
//  Timer width = $clog2(INVULN_CYCLES+1); no wrap, stops at 0.
// CONFIGURATION
//  Macro LIVES_GAIN_EN.
//  Defined: gain_health in ALIVE/INVULN -> health+1, saturating at MAX_HEALTH
//   (at MAX_HEALTH: no change, no error). Simultaneous gain+loss in ALIVE: loss
//   consumes the gain -> health unchanged, life_lost=1, enter INVULN, no game over
//   even when health==0. Gain in INVULN does not affect the timer. Ignored in LOST.
//  Undefined: gain_health port still present (stable instantiation) but ignored.
// STRUCTURE
//  Package lives_pkg: state enum {ALIVE, INVULN, LOST}, state width, helper for
//   timer width. Sub-module invuln_timer: loadable down-counter with load/expire
//   (expire = count==0 while running), instantiated once.
// TESTING
//  Defaults, reset, 3 lost_health pulses spaced > window -> health 3,2,1,0; life_lost x3.
//  health=0, 4th lost_health -> game_over 1 cycle, loss_occurred=1 held, health=0.
//  lost_health during INVULN (INVULN_CYCLES=8) -> ignored; ALIVE exactly 8 cycles after hit.
//  restart in same cycle as lost_health while LOST -> health=3, loss_occurred=0, no life_lost.
//  LIVES_GAIN_EN, MAX_HEALTH=4: 3 gains from 3 -> health 4 (saturated); gain+loss -> 4, life_lost.
//  resetn low mid-INVULN -> next cycle all outputs at reset values, state ALIVE.

Source files
------------

// File: rtl/lives_pkg.sv
// Shared types and helpers for the lives/health tracker.
// Contents: FSM state enum, its width, and the invulnerability timer width helper.
package lives_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    LOST   = 2'd2
  } state_t;

  // Timer width for a window of 'cycles' clocks; never narrower than 1 bit.
  function automatic int unsigned timer_width(input int unsigned cycles);
    if (cycles < 1) return 1;
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/invuln_timer.sv
// Loadable down-counter that times the post-hit invulnerability window.
// Ports:
//   clk, resetn  clock and synchronous active-low reset
//   load         start a window at load_value
//   clear        abort any running window
//   load_value   start value (window length minus one)
//   expire_c     combinational: count reached 0 while running
module invuln_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] load_value,
  output logic         expire_c
);

  logic [W-1:0] count_q;
  logic         running_q;

  assign expire_c = running_q && (count_q == '0);

  // Counter stops at zero; running drops on the cycle expiry is reported.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q   <= '0;
      running_q <= 1'b0;
    end else if (clear) begin
      count_q   <= '0;
      running_q <= 1'b0;
    end else if (load) begin
      count_q   <= load_value;
      running_q <= 1'b1;
    end else if (running_q) begin
      if (count_q == '0) running_q <= 1'b0;
      else               count_q   <= count_q - W'(1);
    end
  end

endmodule

// File: rtl/lives_manager.sv
// Life/health tracker: counts spare lives, consumes one per ball-lost event,
// opens a post-hit invulnerability window and flags game over.
// Optional feature: define LIVES_GAIN_EN to honour gain_health (saturating at
// MAX_HEALTH); otherwise gain_health is present but ignored.
// Ports:
//   clk, resetn    clock and synchronous active-low reset
//   restart        pulse: start a new game without reset
//   lost_health    pulse: ball lost
//   gain_health    pulse: extra-life pickup
//   health         current spare lives
//   invulnerable   high while the post-hit window runs
//   life_lost      1-cycle pulse: a life was consumed
//   loss_occurred  level: game lost, held until reset/restart
//   game_over      1-cycle pulse on entry to LOST
module lives_manager
  import lives_pkg::*;
#(
  parameter int unsigned HEALTH_W      = 10,
  parameter int unsigned START_HEALTH  = 3,
  parameter int unsigned MAX_HEALTH    = 9,
  parameter int unsigned INVULN_CYCLES = 25000000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                restart,
  input  logic                lost_health,
  input  logic                gain_health,
  output logic [HEALTH_W-1:0] health,
  output logic                invulnerable,
  output logic                life_lost,
  output logic                loss_occurred,
  output logic                game_over
);

  localparam int unsigned TIMER_W = timer_width(INVULN_CYCLES);
  localparam int unsigned LOAD_INT = (INVULN_CYCLES == 0) ? 0 : INVULN_CYCLES - 1;
  localparam logic [TIMER_W-1:0]  LOAD_V  = TIMER_W'(LOAD_INT);
  localparam logic [HEALTH_W-1:0] START_H = HEALTH_W'(START_HEALTH);
  localparam logic [HEALTH_W-1:0] MAX_H   = HEALTH_W'(MAX_HEALTH);

  // Reject configurations where the start or ceiling does not fit the counter.
  if (START_HEALTH > MAX_HEALTH || (HEALTH_W < 32 && (MAX_HEALTH >> HEALTH_W) != 0))
  begin : g_bad_params
    $error("lives_manager: need START_HEALTH <= MAX_HEALTH < 2**HEALTH_W");
  end

  state_t              state_q, state_d;
  logic [HEALTH_W-1:0] health_d, health_inc_c;
  logic                invulnerable_d, life_lost_d, loss_d, game_over_d;
  logic                timer_load, timer_clear, timer_expire_c;
  logic                gain_c;

`ifdef LIVES_GAIN_EN
  assign gain_c = gain_health;
`else
  logic unused_gain;
  assign unused_gain = gain_health;
  assign gain_c      = 1'b0;
`endif

  assign health_inc_c = (health >= MAX_H) ? health : health + HEALTH_W'(1);

  invuln_timer #(.W(TIMER_W)) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .load       (timer_load),
    .clear      (timer_clear),
    .load_value (LOAD_V),
    .expire_c   (timer_expire_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ALIVE;
      health        <= START_H;
      invulnerable  <= 1'b0;
      life_lost     <= 1'b0;
      loss_occurred <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      state_q       <= state_d;
      health        <= health_d;
      invulnerable  <= invulnerable_d;
      life_lost     <= life_lost_d;
      loss_occurred <= loss_d;
      game_over     <= game_over_d;
    end
  end

  // Next state and next outputs; restart overrides any same-cycle event.
  always_comb begin
    state_d     = state_q;
    health_d    = health;
    loss_d      = loss_occurred;
    life_lost_d = 1'b0;
    game_over_d = 1'b0;
    timer_load  = 1'b0;
    timer_clear = 1'b0;

    if (restart) begin
      state_d     = ALIVE;
      health_d    = START_H;
      loss_d      = 1'b0;
      timer_clear = 1'b1;
    end else begin
      case (state_q)
        ALIVE: begin
          if (lost_health) begin
            // A simultaneous gain pays for the loss, so health stays put.
            if (gain_c || health != '0) begin
              if (!gain_c) health_d = health - HEALTH_W'(1);
              life_lost_d = 1'b1;
              if (INVULN_CYCLES != 0) begin
                state_d    = INVULN;
                timer_load = 1'b1;
              end
            end else begin
              state_d     = LOST;
              loss_d      = 1'b1;
              game_over_d = 1'b1;
            end
          end else if (gain_c) begin
            health_d = health_inc_c;
          end
        end
        INVULN: begin
          if (gain_c)         health_d = health_inc_c;
          if (timer_expire_c) state_d  = ALIVE;
        end
        LOST: begin
          health_d = '0;
        end
        default: begin
          state_d = ALIVE;
        end
      endcase
    end

    invulnerable_d = (state_d == INVULN);
  end

endmodule

// File: tb/tb_lives_manager.sv
// Self-checking bench for lives_manager with a short invulnerability window.
module tb_lives_manager;

  localparam int unsigned HW = 10;
  localparam int unsigned SH = 3;
  localparam int unsigned MH = 4;
  localparam int unsigned IC = 8;

`ifdef LIVES_GAIN_EN
  localparam bit GAIN_EN = 1'b1;
`else
  localparam bit GAIN_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn, restart, lost_health, gain_health;
  logic [HW-1:0] health;
  logic          invulnerable, life_lost, loss_occurred, game_over;

  always #5 clk = ~clk;

  lives_manager #(
    .HEALTH_W(HW), .START_HEALTH(SH), .MAX_HEALTH(MH), .INVULN_CYCLES(IC)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .restart       (restart),
    .lost_health   (lost_health),
    .gain_health   (gain_health),
    .health        (health),
    .invulnerable  (invulnerable),
    .life_lost     (life_lost),
    .loss_occurred (loss_occurred),
    .game_over     (game_over)
  );

  typedef struct {
    int unsigned health;
    bit inv;
    bit ll;
    bit lo;
    bit go;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: 0 alive, 1 invulnerable, 2 lost; m_left = window cycles remaining.
  int unsigned m_state = 0, m_health = SH, m_left = 0;
  bit          m_lo = 1'b0;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rn, input bit rs, input bit lh, input bit gh, output exp_t e);
    bit g;
    g = GAIN_EN && gh;
    e.ll = 1'b0;
    e.go = 1'b0;
    if (!rn || rs) begin
      m_state = 0; m_health = SH; m_left = 0; m_lo = 1'b0;
    end else if (m_state == 0) begin
      if (lh) begin
        if (g || m_health > 0) begin
          if (!g) m_health = m_health - 1;
          e.ll = 1'b1;
          if (IC > 0) begin m_state = 1; m_left = IC; end
        end else begin
          m_state = 2; m_lo = 1'b1; e.go = 1'b1;
        end
      end else if (g && m_health < MH) begin
        m_health = m_health + 1;
      end
    end else if (m_state == 1) begin
      if (g && m_health < MH) m_health = m_health + 1;
      m_left = m_left - 1;
      if (m_left == 0) m_state = 0;
    end else begin
      m_health = 0;
    end
    e.health = m_health;
    e.inv    = (m_state == 1);
    e.lo     = m_lo;
  endtask

  // One clock: drive inputs, queue the expected response, compare after the edge.
  task automatic cyc(input bit rn, input bit rs, input bit lh, input bit gh, input string tag);
    exp_t e;
    @(negedge clk);
    resetn = rn; restart = rs; lost_health = lh; gain_health = gh;
    model_step(rn, rs, lh, gh, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq({tag, ".health"},        32'(health),        e.health);
    check_eq({tag, ".invulnerable"},  32'(invulnerable),  32'(e.inv));
    check_eq({tag, ".life_lost"},     32'(life_lost),     32'(e.ll));
    check_eq({tag, ".loss_occurred"}, 32'(loss_occurred), 32'(e.lo));
    check_eq({tag, ".game_over"},     32'(game_over),     32'(e.go));
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    resetn = 1'b0; restart = 1'b0; lost_health = 1'b0; gain_health = 1'b0;

    cyc(1'b0, 1'b0, 1'b0, 1'b0, "reset");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, "reset_ev");
    idle(2, "idle");

    // Three hits spaced beyond the window: 3 -> 2 -> 1 -> 0.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0, "hit");
      idle(IC + 2, "window");
    end

    // Fourth hit at zero ends the game; later events are ignored.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "game_over");
    idle(2, "lost_hold");
    cyc(1'b1, 1'b0, 1'b1, 1'b1, "lost_ignore");

    // Restart wins over a same-cycle loss.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, "restart");
    idle(1, "after_restart");

    // Hit, a second hit inside the window, then watch the window close.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "hit2");
    idle(2, "inv");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "inv_hit");
    idle(IC, "inv_tail");

    // Gains toward the ceiling, then gain+loss in the same cycle.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, "restart2");
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0, 1'b1, "gain");
    cyc(1'b1, 1'b0, 1'b1, 1'b1, "gain_loss");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, "gain_inv");
    idle(IC, "gain_tail");

    // Held lost level: first cycle counts, the rest land inside the window.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "level0");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "level1");
    idle(2, "mid_inv");

    // Reset in the middle of the window.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, "reset_mid");
    idle(3, "post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
